// File: rtl/byte_unstriping.sv
// Reassembles 32-bit words that arrive as four parallel lane bytes into a serial
// byte stream. Complete words are buffered in a 2-entry FIFO. Partial words and
// words that find the FIFO full raise sticky error flags.
module byte_unstriping (
  input  logic       clk1Mhz,
  input  logic       reset,
  input  logic [7:0] stripedLane0,
  input  logic [7:0] stripedLane1,
  input  logic [7:0] stripedLane2,
  input  logic [7:0] stripedLane3,
  input  logic       lane0VLD,
  input  logic       lane1VLD,
  input  logic       lane2VLD,
  input  logic       lane3VLD,
  input  logic       laneStrobe,
  output logic [7:0] byteUnstripingOUT,
  output logic       byteUnstripingVLD,
  output logic [1:0] counter,
  output logic       laneError,
  output logic       overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_q [2];
  logic [31:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  out_q, out_d;
  logic        vld_q, vld_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic        all_vld, any_vld, fifo_empty, fifo_full, push, pop;
  logic [31:0] lane_word, head_word;

  // Lane qualification and FIFO handshake decisions for this edge
  always_comb begin
    all_vld    = lane0VLD & lane1VLD & lane2VLD & lane3VLD;
    any_vld    = lane0VLD | lane1VLD | lane2VLD | lane3VLD;
    lane_word  = {stripedLane3, stripedLane2, stripedLane1, stripedLane0};
    head_word  = mem_q[rd_ptr_q];
    fifo_empty = (count_q == 2'd0);
    fifo_full  = (count_q == 2'd2);
    // The head is released on the edge that loads its last byte.
    pop        = (state_q == SEND) && (cnt_q == 2'd2);
    push       = laneStrobe && all_vld && (!fifo_full || pop);
  end

  // FIFO storage, pointers, occupancy and sticky flags
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = lane_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    err_d = err_q | (laneStrobe & any_vld & ~all_vld);
    ovf_d = ovf_q | (laneStrobe & all_vld & fifo_full & ~pop);
  end

  // Output FSM: next state and registered byte/valid/counter
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        out_d = '0;
        vld_d = 1'b0;
        cnt_d = '0;
        if (!fifo_empty) begin
          state_d = SEND;
          out_d   = head_word[7:0];
          vld_d   = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q != 2'd3) begin
          cnt_d = cnt_q + 2'd1;
          out_d = head_word[{cnt_d, 3'b000} +: 8];
        end else if (!fifo_empty) begin
          // Previous head already popped, so head_word is the next word.
          cnt_d = '0;
          out_d = head_word[7:0];
        end else begin
          state_d = IDLE;
          vld_d   = 1'b0;
          out_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk1Mhz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign byteUnstripingOUT = out_q;
  assign byteUnstripingVLD = vld_q;
  assign counter           = cnt_q;
  assign laneError         = err_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Self-checking bench for byte_unstriping: a schedule-based reference model
// (each accepted word owns four consecutive output slots) checked every cycle,
// plus literal expectations for the key scenarios.
module tb_byte_unstriping;

  logic       clk1Mhz = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] l0, l1, l2, l3;
  logic       v0, v1, v2, v3;
  logic       laneStrobe;
  logic [7:0] byteUnstripingOUT;
  logic       byteUnstripingVLD;
  logic [1:0] counter;
  logic       laneError;
  logic       overflow;

  byte_unstriping dut (
    .clk1Mhz           (clk1Mhz),
    .reset             (reset),
    .stripedLane0      (l0),
    .stripedLane1      (l1),
    .stripedLane2      (l2),
    .stripedLane3      (l3),
    .lane0VLD          (v0),
    .lane1VLD          (v1),
    .lane2VLD          (v2),
    .lane3VLD          (v3),
    .laneStrobe        (laneStrobe),
    .byteUnstripingOUT (byteUnstripingOUT),
    .byteUnstripingVLD (byteUnstripingVLD),
    .counter           (counter),
    .laneError         (laneError),
    .overflow          (overflow)
  );

  always #5 clk1Mhz = ~clk1Mhz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: accepted words with their acceptance edge and first output edge
  int          q_acc[$];
  int          q_start[$];
  logic [31:0] q_word[$];
  logic        m_err, m_ovf;
  int          edge_n = 0;

  task automatic model_clear();
    q_acc.delete();
    q_start.delete();
    q_word.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input int t);
    int nv, occ, st;
    if (laneStrobe) begin
      nv = int'(v0) + int'(v1) + int'(v2) + int'(v3);
      if (nv == 4) begin
        // Words still resident after this edge: not yet past their last-byte edge
        occ = 0;
        foreach (q_acc[i]) if (q_acc[i] < t && q_start[i] + 3 > t) occ++;
        if (occ < 2) begin
          st = t + 1;
          if (q_start.size() != 0 && q_start[$] + 4 > st) st = q_start[$] + 4;
          q_acc.push_back(t);
          q_start.push_back(st);
          q_word.push_back({l3, l2, l1, l0});
        end else begin
          m_ovf = 1'b1;
        end
      end else if (nv != 0) begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic model_expect(input int t, output logic [7:0] e_out, output logic e_vld,
                              output logic [1:0] e_cnt);
    logic [31:0] w;
    int idx;
    e_out = 8'h00;
    e_vld = 1'b0;
    e_cnt = 2'd0;
    foreach (q_start[i]) begin
      if (q_start[i] <= t && t <= q_start[i] + 3) begin
        idx   = t - q_start[i];
        w     = q_word[i];
        e_out = w[8*idx +: 8];
        e_vld = 1'b1;
        e_cnt = 2'(idx);
      end
    end
  endtask

  // Per-cycle comparison of DUT against the model
  initial begin
    logic [7:0] e_out;
    logic       e_vld;
    logic [1:0] e_cnt;
    model_clear();
    forever begin
      @(posedge clk1Mhz);
      edge_n++;
      if (reset) model_clear();
      else model_step(edge_n);
      #1;
      model_expect(edge_n, e_out, e_vld, e_cnt);
      chk("cyc_out", 32'(byteUnstripingOUT), 32'(e_out));
      chk("cyc_vld", 32'(byteUnstripingVLD), 32'(e_vld));
      chk("cyc_cnt", 32'(counter), 32'(e_cnt));
      chk("cyc_err", 32'(laneError), 32'(m_err));
      chk("cyc_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic idle_lanes();
    laneStrobe = 1'b0;
    {l3, l2, l1, l0} = 32'hEEEEEEEE;
    {v3, v2, v1, v0} = 4'hF;
  endtask

  task automatic put_word(input logic [31:0] w, input logic [3:0] m);
    {l3, l2, l1, l0} = w;
    {v3, v2, v1, v0} = m;
    laneStrobe = 1'b1;
  endtask

  task automatic strobe_word(input logic [31:0] w, input logic [3:0] m);
    @(negedge clk1Mhz);
    put_word(w, m);
    @(negedge clk1Mhz);
    idle_lanes();
  endtask

  task automatic expect_edge(input string nm, input logic [7:0] o, input logic v,
                             input logic [1:0] c);
    @(posedge clk1Mhz);
    #2;
    chk({nm, "_out"}, 32'(byteUnstripingOUT), 32'(o));
    chk({nm, "_vld"}, 32'(byteUnstripingVLD), 32'(v));
    chk({nm, "_cnt"}, 32'(counter), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    idle_lanes();
    repeat (3) @(negedge clk1Mhz);
    chk("rst_out", 32'(byteUnstripingOUT), 32'h00);
    chk("rst_vld", 32'(byteUnstripingVLD), 32'h0);
    chk("rst_cnt", 32'(counter), 32'h0);
    chk("rst_err", 32'(laneError), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // Strobe on the first edge after reset release; single word latency
    reset = 1'b0;
    put_word(32'hA3A2A1A0, 4'hF);
    @(negedge clk1Mhz);
    idle_lanes();
    expect_edge("single_b0", 8'hA0, 1'b1, 2'd0);
    expect_edge("single_b1", 8'hA1, 1'b1, 2'd1);
    expect_edge("single_b2", 8'hA2, 1'b1, 2'd2);
    expect_edge("single_b3", 8'hA3, 1'b1, 2'd3);
    expect_edge("single_end", 8'h00, 1'b0, 2'd0);

    // Back-to-back words every 4 cycles
    strobe_word(32'h03020100, 4'hF);
    repeat (2) @(negedge clk1Mhz);
    strobe_word(32'h13121110, 4'hF);
    repeat (2) @(negedge clk1Mhz);
    strobe_word(32'h23222120, 4'hF);
    repeat (12) @(negedge clk1Mhz);
    chk("b2b_ovf", 32'(overflow), 32'h0);

    // All-invalid strobe is an idle word
    strobe_word(32'h12345678, 4'h0);
    repeat (2) @(negedge clk1Mhz);
    chk("idle_word_err", 32'(laneError), 32'h0);

    // Partial valid word raises sticky laneError
    strobe_word(32'hDEADBEEF, 4'b1011);
    chk("partial_err", 32'(laneError), 32'h1);
    strobe_word(32'h33323130, 4'hF);
    repeat (8) @(negedge clk1Mhz);
    chk("partial_sticky", 32'(laneError), 32'h1);

    // Three consecutive strobes from IDLE: third is dropped
    @(negedge clk1Mhz); put_word(32'h43424140, 4'hF);
    @(negedge clk1Mhz); put_word(32'h53525150, 4'hF);
    @(negedge clk1Mhz); put_word(32'h63626160, 4'hF);
    @(negedge clk1Mhz); idle_lanes();
    repeat (12) @(negedge clk1Mhz);
    chk("ovf_set", 32'(overflow), 32'h1);

    // Reset clears sticky flags, then full FIFO with push on the pop edge
    @(negedge clk1Mhz); reset = 1'b1;
    @(negedge clk1Mhz); reset = 1'b0;
    chk("rst2_err", 32'(laneError), 32'h0);
    chk("rst2_ovf", 32'(overflow), 32'h0);
    @(negedge clk1Mhz); put_word(32'h73727170, 4'hF);
    @(negedge clk1Mhz); put_word(32'h83828180, 4'hF);
    @(negedge clk1Mhz); idle_lanes();
    @(negedge clk1Mhz);
    @(negedge clk1Mhz); put_word(32'h93929190, 4'hF);
    @(negedge clk1Mhz); idle_lanes();
    chk("popedge_out", 32'(byteUnstripingOUT), 32'h73);
    chk("popedge_cnt", 32'(counter), 32'h3);
    expect_edge("full_w1b0", 8'h80, 1'b1, 2'd0);
    expect_edge("full_w1b1", 8'h81, 1'b1, 2'd1);
    expect_edge("full_w1b2", 8'h82, 1'b1, 2'd2);
    expect_edge("full_w1b3", 8'h83, 1'b1, 2'd3);
    expect_edge("full_w2b0", 8'h90, 1'b1, 2'd0);
    repeat (6) @(negedge clk1Mhz);
    chk("full_pop_ovf", 32'(overflow), 32'h0);

    // Reset asserted while counter=1
    strobe_word(32'hB3B2B1B0, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk1Mhz);
      #2;
      if (counter == 2'd1 && byteUnstripingVLD) found = 1'b1;
    end
    chk("wait_cnt1", 32'(found), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out", 32'(byteUnstripingOUT), 32'h00);
    chk("midrst_vld", 32'(byteUnstripingVLD), 32'h0);
    chk("midrst_cnt", 32'(counter), 32'h0);
    @(negedge clk1Mhz);
    @(negedge clk1Mhz); reset = 1'b0;
    repeat (2) @(negedge clk1Mhz);
    chk("post_rst_vld", 32'(byteUnstripingVLD), 32'h0);
    strobe_word(32'hC3C2C1C0, 4'hF);
    expect_edge("post_b0", 8'hC0, 1'b1, 2'd0);
    expect_edge("post_b1", 8'hC1, 1'b1, 2'd1);
    expect_edge("post_b2", 8'hC2, 1'b1, 2'd2);
    expect_edge("post_b3", 8'hC3, 1'b1, 2'd3);
    expect_edge("post_end", 8'h00, 1'b0, 2'd0);

    repeat (3) @(negedge clk1Mhz);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 The block SHALL expose the following ports, one clock domain only, listed clock and reset first:
REQ-002 clk1Mhz  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-004 stripedLane0..stripedLane3  input  8 each  lane bytes; lane0 carries byte 0 of a word, lane3 carries byte 3.
REQ-005 lane0VLD..lane3VLD  input  1 each  per-lane valid qualifiers.
REQ-006 laneStrobe  input  1  one-cycle pulse marking the cycle in which the lanes are sampled (nominally every 4th clk1Mhz cycle).
REQ-007 byteUnstripingOUT  output  8  reassembled serial byte, registered.
REQ-008 byteUnstripingVLD  output  1  byteUnstripingOUT valid, registered.
REQ-009 counter  output  2  index (0..3) of the lane whose byte is on byteUnstripingOUT, registered.
REQ-010 laneError  output  1  sticky: a partial-valid word was seen.
REQ-011 overflow  output  1  sticky: a complete word was dropped because the buffer was full.

Function
REQ-012 Lane sampling SHALL occur only on edges where laneStrobe=1; lane inputs are ignored otherwise.
REQ-013 Strobe with all four VLD=1: the word {lane3,lane2,lane1,lane0} SHALL be pushed into a 2-entry word FIFO.
REQ-014 Strobe with all four VLD=0: no push, no flag change (idle word).
REQ-015 Strobe with 1-3 VLD=1: the word SHALL be discarded and laneError SHALL set to 1 and remain 1 until reset.
REQ-016 Strobe with all VLD=1 while the FIFO holds 2 words and no pop occurs on that edge: the word SHALL be discarded and overflow SHALL set to 1 (sticky until reset).
REQ-017 Push and pop on the same edge with the FIFO full SHALL accept the push (no overflow).
REQ-018 The output FSM SHALL have two states: IDLE and SEND; reset state IDLE.
REQ-019 IDLE -> SEND on the first edge where the FIFO is non-empty; on that edge the output registers load byteUnstripingOUT=head lane0 byte, counter=0, byteUnstripingVLD=1.
REQ-020 In SEND, each edge SHALL advance counter by 1 and present the head word's byte[counter]; lane order is strictly 0,1,2,3.
REQ-021 The head word SHALL be popped on the edge that loads its byte 3 (counter=3).
REQ-022 On the edge after counter=3: if the FIFO is non-empty (including a word pushed on the pop edge), SEND SHALL continue with counter wrapping to 0 and the next word's lane0 byte, with no bubble; otherwise SEND -> IDLE with byteUnstripingVLD=0 and counter=0.
REQ-023 Latency: a word sampled at edge k into an empty FIFO in IDLE SHALL appear as bytes 0..3 after edges k+1..k+4.
REQ-024 Sustained strobes every 4 cycles with all-valid words SHALL produce a continuous byte stream with byteUnstripingVLD constantly 1 and no overflow.
REQ-025 When byteUnstripingVLD=0, byteUnstripingOUT SHALL be 8'h00.

Reset
REQ-026 While reset=1: byteUnstripingOUT=8'h00, byteUnstripingVLD=0, counter=2'b00, laneError=0, overflow=0, FIFO empty, FSM IDLE.
REQ-027 Reset asserted mid-word SHALL drop all buffered and partially emitted words; after release, output resumes only with the next complete word sampled.
REQ-028 A laneStrobe coincident with the first edge after reset deassertion SHALL be sampled normally.

Verification
REQ-029 Single word: strobe, lanes 8'hA0,8'hA1,8'hA2,8'hA3 all valid -> after edges k+1..k+4 OUT=A0,A1,A2,A3, counter 0,1,2,3, VLD=1; VLD=0 after k+5.
REQ-030 Back-to-back: strobes every 4 cycles with words 00-03,10-13,20-23 -> 12 contiguous VLD=1 bytes 00,01,02,03,10,...,23; overflow=0.
REQ-031 Partial valid: strobe with lane2VLD=0 -> no output bytes, laneError=1 and stays 1 across later good words, which output correctly.
REQ-032 Overflow: three all-valid strobes on consecutive cycles from IDLE -> first two words emitted in order, third dropped, overflow=1.
REQ-033 Full with simultaneous pop: FIFO at 2 words, strobe on the counter=3 edge -> word accepted, overflow=0, all three words emitted contiguously.
REQ-034 Reset mid-stream: assert reset while counter=1 -> outputs clear immediately to 00/0/0; after release the next strobed word 8'hC0..C3 outputs with correct latency.
